pool_window_feeder: RTL and testbench

Upstream stage of the fp32 2x2 average-pooling unit. Accepts a row-major stream of fp32 feature-map pixels from the convolution stage, buffers one even row in a line buffer, and replays each complete 2x2 window as a 4-beat burst (TL, TR, BL, BR). Output port naming and the `start`-while-valid protocol match what the averaging stage samples on each rising edge. No arithmetic is performed on pixel data; words pass through bit-exact.

---
 rtl/pool_window_feeder.sv | 169 ++++++++++++++++
 tb/tb_pool_window_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Feeds 2x2 pooling windows to the averaging stage. An even row is held in a line buffer;
// odd-row pixels complete each window, which is replayed as a 4-beat TL/TR/BL/BR burst.
module pool_window_feeder #(
   parameter int unsigned IMG_W = 4,
   parameter int unsigned IMG_H = 4,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_pixel,
   output logic          in_ready,
   output logic          start,
   output logic [DW-1:0] In1,
   output logic          win_first,
   output logic          frame_done
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

   typedef enum logic [2:0] {
      StFillTop,
      StFillBot,
      StEmit0,
      StEmit1,
      StEmit2,
      StEmit3
   } state_e;

   state_e state_q, state_d;

   logic [CW-1:0] col_q, col_d, col_prev;
   logic [RW-1:0] row_q, row_d;

   logic [DW-1:0] lb_q [IMG_W];
   logic [DW-1:0] bl_q;
   logic [DW-1:0] win_tl_q, win_tr_q, win_bl_q, win_br_q;
   logic          last_win_q, row_end_q;

   logic          accept, odd_row, col_last, lb_we, bl_we, win_we;

   logic          in_ready_q, in_ready_d;
   logic          start_q, start_d;
   logic [DW-1:0] out_q, out_d;
   logic          win_first_q, win_first_d;
   logic          frame_done_q, frame_done_d;

   // in_ready_q is only ever high in a FILL state, so it gates acceptance on its own.
   assign accept   = in_valid && in_ready_q;
   assign odd_row  = row_q[0];
   assign col_last = (col_q == ColLast);
   assign col_prev = col_q - CW'(1);
   assign lb_we    = accept && !odd_row;
   assign bl_we    = accept && odd_row && !col_q[0];
   assign win_we   = accept && odd_row && col_q[0];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;

      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      unique case (state_q)
         StFillTop: if (accept && col_last) state_d = StFillBot;
         StFillBot: if (win_we)             state_d = StEmit0;
         StEmit0:   state_d = StEmit1;
         StEmit1:   state_d = StEmit2;
         StEmit2:   state_d = StEmit3;
         StEmit3:   state_d = row_end_q ? StFillTop : StFillBot;
         default:   state_d = StFillTop;
      endcase
   end

   // Outputs are registered from the current state, so beats trail the FSM by one cycle.
   always_comb begin
      in_ready_d   = (state_d == StFillTop) || (state_d == StFillBot);
      start_d      = 1'b0;
      out_d        = '0;
      win_first_d  = 1'b0;
      frame_done_d = 1'b0;

      unique case (state_q)
         StEmit0: begin
            start_d     = 1'b1;
            out_d       = win_tl_q;
            win_first_d = 1'b1;
         end
         StEmit1: begin
            start_d = 1'b1;
            out_d   = win_tr_q;
         end
         StEmit2: begin
            start_d = 1'b1;
            out_d   = win_bl_q;
         end
         StEmit3: begin
            start_d      = 1'b1;
            out_d        = win_br_q;
            frame_done_d = last_win_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StFillTop;
         col_q        <= '0;
         row_q        <= '0;
         bl_q         <= '0;
         win_tl_q     <= '0;
         win_tr_q     <= '0;
         win_bl_q     <= '0;
         win_br_q     <= '0;
         last_win_q   <= 1'b0;
         row_end_q    <= 1'b0;
         in_ready_q   <= 1'b0;
         start_q      <= 1'b0;
         out_q        <= '0;
         win_first_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         in_ready_q   <= in_ready_d;
         start_q      <= start_d;
         out_q        <= out_d;
         win_first_q  <= win_first_d;
         frame_done_q <= frame_done_d;
         if (bl_we) begin
            bl_q <= in_pixel;
         end
         if (win_we) begin
            win_tl_q   <= lb_q[col_prev];
            win_tr_q   <= lb_q[col_q];
            win_bl_q   <= bl_q;
            win_br_q   <= in_pixel;
            last_win_q <= (row_q == RowLast) && col_last;
            row_end_q  <= col_last;
         end
      end
   end

   // Line buffer holds data only; its contents need no reset.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb_q[col_q] <= in_pixel;
      end
   end

   assign in_ready   = in_ready_q;
   assign start      = start_q;
   assign In1        = out_q;
   assign win_first  = win_first_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: a 4x4 instance and a 6x2 instance checked against a
// scoreboard of expected window beats built from the driven pixel values.
module tb_pool_window_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld [2];
   logic [31:0] pix [2];
   logic        rdy [2];
   logic        st  [2];
   logic [31:0] w   [2];
   logic        wf  [2];
   logic        fd  [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int br_cyc   = 0;
   int nready   = 0;
   int run [2];
   int fd_cnt [2];
   bit skip_run = 1'b0;

   logic [33:0] exp_a[$];
   logic [33:0] exp_b[$];
   logic [33:0] mon_e;
   logic [31:0] cap [4];
   int          cap_n = 0;
   logic [31:0] fd_word = '0;
   bit          fd_word_set = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pool_window_feeder #(.IMG_W(4), .IMG_H(4), .DW(32)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (vld[0]),
      .in_pixel   (pix[0]),
      .in_ready   (rdy[0]),
      .start      (st[0]),
      .In1        (w[0]),
      .win_first  (wf[0]),
      .frame_done (fd[0])
   );

   pool_window_feeder #(.IMG_W(6), .IMG_H(2), .DW(32)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (vld[1]),
      .in_pixel   (pix[1]),
      .in_ready   (rdy[1]),
      .start      (st[1]),
      .In1        (w[1]),
      .win_first  (wf[1]),
      .frame_done (fd[1])
   );

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // fp32 encoding of a small positive integer.
   function automatic logic [31:0] fp(input int unsigned v);
      int unsigned e = 0;
      while ((v >> (e + 1)) != 0) e++;
      return {1'b0, 8'(127 + e), 23'(v << (23 - e))};
   endfunction

   task automatic push_frame(input int sel, input int base, input int iw, input int ih);
      int tl;
      for (int r = 0; r < ih / 2; r++) begin
         for (int c = 0; c < iw / 2; c++) begin
            tl = base + 2 * r * iw + 2 * c;
            for (int b = 0; b < 4; b++) begin
               logic [33:0] e;
               int v;
               v = tl + ((b == 1 || b == 3) ? 1 : 0) + ((b >= 2) ? iw : 0);
               e = {(b == 3 && r == ih / 2 - 1 && c == iw / 2 - 1) ? 1'b1 : 1'b0,
                    (b == 0) ? 1'b1 : 1'b0, fp(v)};
               if (sel == 0) exp_a.push_back(e);
               else exp_b.push_back(e);
            end
         end
      end
   endtask

   task automatic send(input int sel, input int v, input bit is_br, input bit gaps);
      int  budget = 200;
      bit  acc = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge clk);
         budget--;
         if (!rdy[0]) nready++;
         pix[sel] = fp(v);
         vld[sel] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         acc = vld[sel] && rdy[sel];
      end
      if (!acc) chk("send_timeout", 34'd0, 34'd1);
      if (acc && is_br && sel == 0) br_cyc = cyc + 1;
   endtask

   task automatic frame(input int sel, input int base, input int iw, input int ih,
                        input bit gaps);
      push_frame(sel, base, iw, ih);
      for (int k = 0; k < iw * ih; k++) begin
         send(sel, base + k, ((k / iw) % 2 == 1) && ((k % iw) % 2 == 1), gaps);
      end
   endtask

   task automatic drain();
      int budget = 300;
      bit done = 1'b0;
      while (!done && budget > 0) begin
         @(negedge clk);
         budget--;
         vld[0] = 1'b0;
         vld[1] = 1'b0;
         if (!rdy[0]) nready++;
         done = (exp_a.size() == 0) && (exp_b.size() == 0) && !st[0] && !st[1];
      end
      if (!done) chk("drain_timeout", 34'd0, 34'd1);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (st[i]) begin
            run[i]++;
            if ((i == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
               chk("unexpected_beat", 34'd1, 34'd0);
            end else begin
               mon_e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
               chk((i == 0) ? "beat_a" : "beat_b", {fd[i], wf[i], w[i]}, mon_e);
            end
            if (i == 0 && wf[0]) chk("tl_latency", 34'(cyc), 34'(br_cyc + 1));
            if (i == 0 && cap_n < 4) begin
               cap[cap_n] = w[0];
               cap_n++;
            end
            if (i == 0 && fd[0] && !fd_word_set) begin
               fd_word     = w[0];
               fd_word_set = 1'b1;
            end
         end else begin
            if (run[i] != 0 && !skip_run) chk("burst_len", 34'(run[i]), 34'd4);
            run[i] = 0;
            chk("idle_flags", {32'd0, wf[i], fd[i]}, 34'd0);
         end
         if (fd[i]) fd_cnt[i]++;
      end
   end

   initial begin
      run[0] = 0; run[1] = 0; fd_cnt[0] = 0; fd_cnt[1] = 0;
      rst = 1'b1;
      vld[0] = 1'b0; vld[1] = 1'b0; pix[0] = '0; pix[1] = '0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {rdy[0], st[0], wf[0], fd[0], w[0]}, 36'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {33'd0, rdy[0]}, 34'd1);

      // Frame 1, continuous valid.
      nready = 0;
      frame(0, 1, 4, 4, 1'b0);
      drain();
      chk("first_tl", {2'b0, cap[0]}, {2'b0, 32'h3F800000});
      chk("first_tr", {2'b0, cap[1]}, {2'b0, 32'h40000000});
      chk("first_bl", {2'b0, cap[2]}, {2'b0, 32'h40A00000});
      chk("first_br", {2'b0, cap[3]}, {2'b0, 32'h40C00000});
      chk("frame_done_word", {2'b0, fd_word}, {2'b0, 32'h41800000});
      chk("ready_low_cycles", 34'(nready), 34'd16);
      chk("fd_count_1", 34'(fd_cnt[0]), 34'd1);

      // Same frame with random valid gaps.
      nready = 0;
      frame(0, 1, 4, 4, 1'b1);
      drain();
      chk("ready_low_gaps", 34'(nready), 34'd16);
      chk("fd_count_2", 34'(fd_cnt[0]), 34'd2);

      // Two back-to-back frames.
      frame(0, 1, 4, 4, 1'b0);
      frame(0, 17, 4, 4, 1'b0);
      drain();
      chk("fd_count_b2b", 34'(fd_cnt[0]), 34'd4);

      // Reset during EMIT1 of window 2.
      push_frame(0, 1, 4, 4);
      for (int k = 0; k < 8; k++) begin
         send(0, k + 1, ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1), 1'b0);
      end
      @(negedge clk);
      vld[0] = 1'b0;
      @(negedge clk);
      chk("win2_tl_seen", {32'd0, st[0], wf[0]}, 34'd3);
      skip_run = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("midburst_rst_out", {rdy[0], st[0], wf[0], fd[0], w[0]}, 36'd0);
      rst = 1'b0;
      exp_a.delete();
      @(negedge clk);
      chk("ready_after_rst2", {33'd0, rdy[0]}, 34'd1);
      skip_run = 1'b0;
      frame(0, 1, 4, 4, 1'b0);
      drain();
      chk("fd_count_rst", 34'(fd_cnt[0]), 34'd5);

      // 6x2 instance.
      frame(1, 1, 6, 2, 1'b0);
      drain();
      chk("fd_count_b", 34'(fd_cnt[1]), 34'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
